// File: rtl/tdc_capture_ctrl.sv
// tdc_capture_ctrl: launches the delay line, ones-counts each capture and sums 2^ACC_LOG2 samples.
module tdc_capture_ctrl #(
  parameter int TAPS     = 32,
  parameter int ACC_LOG2 = 3,
  parameter int RECOVER  = 4,
  parameter int CNT_W    = $clog2(TAPS+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TAPS-1:0]           therm_in,
  output logic                      launch,
  output logic                      busy,
  output logic [CNT_W+ACC_LOG2-1:0] result,
  output logic                      result_valid,
  output logic                      sat
);
  localparam int RES_W = CNT_W + ACC_LOG2;
  localparam int SW    = ACC_LOG2 > 0 ? ACC_LOG2 : 1;
  localparam int RW    = RECOVER > 1 ? $clog2(RECOVER) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ACCUM, S_RECOVER, S_DONE} state_t;
  state_t           state, next;
  logic [TAPS-1:0]  cap_reg;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] acc, acc_next;
  logic [SW-1:0]    sample_idx;
  logic [RW-1:0]    rcnt;
  logic             sat_acc, sat_now, last;
  // plain ones-count so bubbles in the thermometer code still contribute
  always_comb begin
    cnt = '0;
    for (int i = 0; i < TAPS; i++) cnt = cnt + CNT_W'(cap_reg[i]);
  end
  assign sat_now  = cnt == CNT_W'(TAPS);
  assign acc_next = acc + RES_W'(cnt);
  assign last     = sample_idx == SW'((1 << ACC_LOG2) - 1);
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:    next = start ? S_LAUNCH : S_IDLE;
      S_LAUNCH:  next = S_ACCUM;
      S_ACCUM:   next = last ? S_DONE : S_RECOVER;
      S_RECOVER: next = rcnt == '0 ? S_LAUNCH : S_RECOVER;
      S_DONE:    next = S_IDLE;
      default:   next = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      launch       <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      sat          <= 1'b0;
      cap_reg      <= '0;
      acc          <= '0;
      sample_idx   <= '0;
      rcnt         <= '0;
      sat_acc      <= 1'b0;
    end else begin
      state        <= next;
      launch       <= next == S_LAUNCH;
      busy         <= next != S_IDLE;
      result_valid <= next == S_DONE;
      if (state == S_IDLE && start) begin
        acc        <= '0;
        sample_idx <= '0;
        sat_acc    <= 1'b0;
      end
      if (state == S_LAUNCH) cap_reg <= therm_in;
      if (state == S_ACCUM) begin
        acc     <= acc_next;
        sat_acc <= sat_acc | sat_now;
        if (last) begin
          result <= acc_next;
          sat    <= sat_acc | sat_now;
        end else begin
          sample_idx <= sample_idx + SW'(1);
          rcnt       <= RW'(RECOVER - 1);
        end
      end
      if (state == S_RECOVER && rcnt != '0) rcnt <= rcnt - RW'(1);
    end
  end
endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// tb_tdc_capture_ctrl: random and directed measurements scored against a popcount-sum model.
module tb_tdc_capture_ctrl;
  logic        clk = 0, rst = 1, start = 0;
  logic [31:0] therm_in = '0;
  logic        launch, busy, result_valid, sat;
  logic [8:0]  result;

  tdc_capture_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .therm_in(therm_in),
    .launch(launch), .busy(busy), .result(result),
    .result_valid(result_valid), .sat(sat)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int res; bit sat; int at;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: launch shape, and scoreboard pop on every result_valid
  int  nl = 0, last_l = 0;
  bit  prev_l = 0;
  always @(negedge clk) begin
    exp_t e;
    if (launch && !prev_l) begin
      if (nl > 0) chk("launch_spacing", cyc - last_l, 6);
      nl++;
      last_l = cyc;
    end
    if (launch && prev_l) chk("launch_width", 2, 1);
    if (result_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("sat", sat, e.sat);
        chk("valid_cycle", cyc, e.at);
        chk("launch_count", nl, 8);
      end
      nl = 0;
    end
    if (!busy) nl = 0;
    prev_l = launch;
  end

  function automatic exp_t model(logic [31:0] v[8], int at);
    exp_t e;
    e.res = 0; e.sat = 0; e.at = at;
    foreach (v[k]) begin
      e.res += $countones(v[k]);
      e.sat |= v[k] == 32'hFFFF_FFFF;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_tap();
    int n;
    n = $urandom_range(0, 32);
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2, 3: return n == 32 ? '1 : (32'h1 << n) - 1;
      default: return $urandom;
    endcase
  endfunction

  // sample k launches in cycle 1+6k after the start edge; therm_in is scrambled outside capture windows
  task automatic run_meas(input logic [31:0] v[8], input bit extra);
    therm_in = v[0];
    start = 1;
    q.push_back(model(v, cyc + 45));
    @(negedge clk) start = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      therm_in = $urandom;
      if (extra && k == 1) start = 1;
      if (k < 7) begin
        @(negedge clk) start = 0;
        repeat (3) @(negedge clk);
        therm_in = v[k+1];
        @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(output logic [31:0] v[8], input logic [31:0] x);
    foreach (v[k]) v[k] = x;
  endtask

  initial begin
    logic [31:0] v[8];
    int c;
    repeat (2) @(negedge clk);
    chk("rst_launch", launch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_sat", sat, 0);
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_outputs", {launch, busy, result, result_valid, sat}, 0);
    end
    // abort during sample 4 launch
    therm_in = 32'h3;
    start = 1;
    @(negedge clk) start = 0;
    repeat (24) @(negedge clk);
    chk("midrun_launch_hi", launch, 1);
    rst = 1;
    @(negedge clk);
    chk("midrun_launch", launch, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_result", result, 0);
    rst = 0;
    @(negedge clk);
    fill(v, 32'h0000_000F); run_meas(v, 0);
    fill(v, 32'h0000_FFFF); run_meas(v, 0);
    fill(v, 32'h0000_FF7F); run_meas(v, 0);
    fill(v, 32'h0000_0001); run_meas(v, 0);
    fill(v, 32'h0000_00FF); v[3] = '1; run_meas(v, 0);
    fill(v, 32'h0000_00FF); run_meas(v, 0);
    fill(v, 32'h0000_0F0F); run_meas(v, 1);
    fill(v, 32'h0000_0000); run_meas(v, 0);
    repeat (8) begin
      foreach (v[k]) v[k] = rand_tap();
      run_meas(v, $urandom_range(0, 1));
    end
    // start held high: three measurements 46 cycles apart
    therm_in = 32'h0000_FFFF;
    c = cyc;
    start = 1;
    fill(v, 32'h0000_FFFF);
    for (int m = 0; m < 3; m++) q.push_back(model(v, c + 45 + 46 * m));
    repeat (100) @(negedge clk);
    start = 0;
    for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) chk("pending_results", q.size(), 0);
    repeat (60) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
